// File: rtl/spi_mstr_pkg.sv
// spi_mstr_pkg: shared state, mode types and sizing helper for spi_mstr_param
package spi_mstr_pkg;
  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} state_t;
  typedef logic [1:0] spi_mode_t;
  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period SCLK generator with leading/trailing edge strobes
module spi_sclk_gen #(
  parameter int SCLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cpol,
  output logic SCLK,
  output logic lead,
  output logic trail
);
  localparam int HALF = SCLK_DIV / 2;
  localparam int HW = $clog2(HALF);
  logic [HW-1:0] cnt_q, cnt_d;
  logic sclk_q, sclk_d, tick;
  always_comb begin
    tick = en && cnt_q == '0;
    cnt_d = (!en || tick) ? HW'(HALF - 1) : cnt_q - 1'b1;
    sclk_d = !en ? cpol : (tick ? !sclk_q : sclk_q);
    lead = tick && sclk_q == cpol;
    trail = tick && sclk_q != cpol;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
  assign SCLK = en ? sclk_q : cpol;
endmodule

// File: rtl/spi_mstr_param.sv
// spi_mstr_param: multi-frame SPI master, any SPI mode per transaction.
// Optional SPI_MSTR_ABORT_EN adds an abort input that drops any transfer back to IDLE.
module spi_mstr_param
  import spi_mstr_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SCLK_DIV    = 32,
  parameter int FRONT_PORCH = 4,
  parameter int BACK_PORCH  = 4,
  parameter int NUM_FRAMES  = 2,
  parameter int FRAME_GAP   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
`ifdef SPI_MSTR_ABORT_EN
  input  logic              abort,
`endif
  input  logic [DATA_W-1:0] cmd,
  input  logic [1:0]        mode,
  input  logic              MISO,
  output logic              SCLK,
  output logic              SS_n,
  output logic              MOSI,
  output logic              busy,
  output logic              frame_done,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);
  localparam int SHIFT_LEN = DATA_W * SCLK_DIV;
  localparam int CW = $clog2(max2(max2(FRONT_PORCH, BACK_PORCH), max2(SHIFT_LEN, FRAME_GAP)));
  localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fc_q, fc_d;
  logic [DATA_W-1:0] cmd_q, cmd_d, sh_q, sh_d, rd_q, rd_d;
  spi_mode_t mode_q, mode_d;
  logic mosi_q, mosi_d, fd_q, fd_d, done_q, done_d;
  logic lead, trail, last, smp, drv, ab;
`ifdef SPI_MSTR_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif
  spi_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk(clk), .rst(rst), .en(state_q == SHIFT), .cpol(mode_q[1]),
    .SCLK(SCLK), .lead(lead), .trail(trail)
  );
  assign smp = mode_q[0] ? trail : lead;
  assign drv = mode_q[0] ? lead : trail;
  assign last = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = last ? cnt_q : cnt_q - 1'b1;
    fc_d = fc_q;
    cmd_d = cmd_q;
    mode_d = mode_q;
    sh_d = sh_q;
    mosi_d = mosi_q;
    rd_d = rd_q;
    fd_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (wrt) begin
        state_d = FRONT;
        cnt_d = CW'(FRONT_PORCH - 1);
        fc_d = '0;
        cmd_d = cmd;
        mode_d = mode;
        sh_d = cmd;
        mosi_d = mode[0] ? mosi_q : cmd[DATA_W-1];
      end
      FRONT: if (last) begin
        state_d = SHIFT;
        cnt_d = CW'(SHIFT_LEN - 1);
      end
      SHIFT: begin
        if (smp) sh_d = {sh_q[DATA_W-2:0], MISO};
        // in CPHA=0 the final trailing edge has no further bit to present
        if (drv && !(!mode_q[0] && last)) mosi_d = sh_q[DATA_W-1];
        if (last) begin
          state_d = BACK;
          cnt_d = CW'(BACK_PORCH - 1);
        end
      end
      BACK: if (last) begin
        rd_d = sh_q;
        fd_d = 1'b1;
        done_d = fc_q == FW'(NUM_FRAMES - 1);
        state_d = done_d ? IDLE : GAP;
        fc_d = done_d ? fc_q : fc_q + 1'b1;
        cnt_d = CW'(FRAME_GAP - 1);
      end
      GAP: begin
        sh_d = cmd_q;
        if (last) begin
          state_d = FRONT;
          cnt_d = CW'(FRONT_PORCH - 1);
          mosi_d = mode_q[0] ? mosi_q : cmd_q[DATA_W-1];
        end
      end
      default: state_d = IDLE;
    endcase
    if (ab && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d = '0;
      rd_d = rd_q;
      fd_d = 1'b0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fc_q <= '0;
      cmd_q <= '0;
      mode_q <= 2'b11;
      sh_q <= '0;
      mosi_q <= 1'b0;
      rd_q <= '0;
      fd_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fc_q <= fc_d;
      cmd_q <= cmd_d;
      mode_q <= mode_d;
      sh_q <= sh_d;
      mosi_q <= mosi_d;
      rd_q <= rd_d;
      fd_q <= fd_d;
      done_q <= done_d;
    end
  end
  assign SS_n = state_q == IDLE || state_q == GAP;
  assign MOSI = mosi_q;
  assign busy = state_q != IDLE;
  assign frame_done = fd_q;
  assign done = done_q;
  assign rd_data = rd_q;
endmodule
